systolic_skew_feeder: RTL and testbench
=======================================

// Module: systolic_skew_feeder
// PURPOSE
//   Upstream stage of the PE array row edge: accepts one N-lane operand vector per cycle and
//   emits it diagonally skewed (lane i delayed i cycles) to the N PE rows, each lane paired
//   with a per-lane fire strobe. After the last vector, drains the skew and pulses done.
//   Bubbles (no valid input) propagate as skewed fire=0 slots, so PEs never see stale data.
// PARAMETERS
//   N      4    number of lanes (PE rows); N >= 2
//   DW     8    operand width; matches PE a/w input width
//   CNTW   16   width of beat counter
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      in_vec/in_last valid this cycle
//   in_ready   out  1      feeder accepts a vector this cycle
//   in_vec     in   N*DW   lane i = in_vec[i*DW +: DW]
//   in_last    in   1      marks final vector of the stream (qualified by in_valid)
//   fire       out  N      fire[i] drives PE row i fire input
//   a_out      out  N*DW   lane i operand to PE row i; zero when fire[i]=0
//   done       out  1      1-cycle pulse: stream fully presented on all lanes
//   beat_cnt   out  CNTW   vectors accepted since last IDLE entry; saturates at all-ones
// BEHAVIOUR
//   Reset (rst=1 at edge): fire=0, a_out=0, done=0, beat_cnt=0, all delay stages cleared,
//     state=IDLE; in_ready=0 while rst is high. Reset mid-stream discards all in-flight data.
//   Handshake: beat accepted in cycle c iff in_valid & in_ready. in_vec held stable by source
//     only while in_valid & ~in_ready; no combinational path in_valid -> in_ready.
//   Latency: lane i of beat accepted in cycle c appears on a_out/fire[i] in cycle c+1+i.
//   Non-accepted cycle in IDLE/STREAM injects bubble: lane i shows fire=0, a_out=0 at c+1+i.
//   FSM: IDLE  - in_ready=1; accept -> STREAM (or DRAIN if in_last), beat_cnt=1.
//        STREAM- in_ready=1; accept & in_last -> DRAIN, drain_cnt=N-1; beat_cnt++ on accept.
//        DRAIN - in_ready=0; bubbles injected; drain_cnt decrements; at 0 -> IDLE.
//     done asserted in cycle L+N (L = cycle last beat accepted), same cycle fire[N-1]
//     presents the last beat; in_ready returns to 1 in cycle L+N+1.
//   Single-beat stream (first beat has in_last): IDLE -> DRAIN directly; done at L+N.
//   beat_cnt cleared on IDLE->STREAM/DRAIN transition (then counts that beat), holds in DRAIN
//     and IDLE; saturates, no wrap.
//   in_last with in_valid=0 ignored. Back-to-back streams: next stream accepted at L+N+1,
//     no overlap with previous skew; fire never asserted for two beats in one lane slot.
//   All outputs registered.
// STRUCTURE
//   systola_pkg: N/DW defaults, typedef logic [DW-1:0] operand_t, FSM state enum
//     {IDLE, STREAM, DRAIN}.
//   Sub-module skew_delay_line #(DEPTH, DW): DEPTH-stage shift of {valid, data}, sync reset;
//     instantiated per lane with DEPTH=i+1 via generate. FSM/counters in top.
// TESTING (N=4, DW=8)
//   1 reset: rst high 3 cycles mid-stream -> next cycle fire=0000, a_out=0, done=0,
//     in_ready=0; after release in_ready=1, beat_cnt=0.
//   2 skew: accept vec {lane3..0}={4,3,2,1} at c=5, single beat+last -> a_out lane0=1 @6,
//     lane1=2 @7, lane2=3 @8, lane3=4 @9 with matching fire bit; done @9; in_ready=0 @6..9, 1 @10.
//   3 continuous: 8 beats lane values k*10+i, last at beat 8 -> each lane fires 8
//     consecutive cycles, values in order; beat_cnt=8; done exactly once.
//   4 bubbles: valid pattern 1,0,1,1(last) -> fire[0] pattern 1,0,1,1 from c+1,
//     fire[3] same pattern shifted 3 cycles; a_out=0 in bubble slots.
//   5 backpressure: hold in_valid with new vector during DRAIN -> not accepted until
//     in_ready=1 at L+N+1; no corruption of draining lanes.
//   6 saturation: force 65537 beats (CNTW=16) -> beat_cnt holds 65535.

Source files
------------

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic skew feeder: default geometry,
// the operand type handed to a PE row, and the feeder FSM state encoding.
package systolic_skew_feeder_pkg;

  localparam int N_DEF    = 4;   // lanes (PE rows)
  localparam int DW_DEF   = 8;   // operand width
  localparam int CNTW_DEF = 16;  // beat counter width

  typedef logic [DW_DEF-1:0] operand_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Bundle between the operand source and the skew feeder, plus the
// per-lane outputs that go toward the PE array row edge.
//   in_valid/in_ready/in_vec/in_last : upstream vector handshake
//   fire/a_out                       : per-lane strobe and operand to PE rows
//   done/beat_cnt                    : stream completion pulse and beat count
// master = operand source side, slave = feeder side.
interface systolic_skew_feeder_if
  import systolic_skew_feeder_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int DW   = DW_DEF,
  parameter int CNTW = CNTW_DEF
);

  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_vec;
  logic            in_last;
  logic [N-1:0]    fire;
  logic [N*DW-1:0] a_out;
  logic            done;
  logic [CNTW-1:0] beat_cnt;

  modport master (
    output in_valid, in_vec, in_last,
    input  in_ready, fire, a_out, done, beat_cnt
  );

  modport slave (
    input  in_valid, in_vec, in_last,
    output in_ready, fire, a_out, done, beat_cnt
  );

endinterface

// File: rtl/systolic_skew_feeder_skew_delay_line.sv
// Fixed-depth shift register carrying {valid, data} for one lane.
// Data is zeroed whenever valid is low, so a bubble slot always
// presents operand 0 at the output.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_data   : slot entering the line
//   out_valid, out_data : slot leaving the line DEPTH cycles later
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic          valid_r [DEPTH];
  logic [DW-1:0] data_r  [DEPTH];

  // Shift stages forward each cycle; reset empties the whole line.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_r[k] <= 1'b0;
        data_r[k]  <= {DW{1'b0}};
      end
    end else begin
      valid_r[0] <= in_valid;
      data_r[0]  <= in_valid ? in_data : {DW{1'b0}};
      for (int k = 1; k < DEPTH; k++) begin
        valid_r[k] <= valid_r[k-1];
        data_r[k]  <= data_r[k-1];
      end
    end
  end

  assign out_valid = valid_r[DEPTH-1];
  assign out_data  = data_r[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Row-edge feeder for the PE array. Accepts one N-lane vector per cycle
// and presents lane i to PE row i delayed by i+1 cycles, with a fire
// strobe per lane. After the beat marked last, input is blocked while the
// skew drains; done pulses in the cycle the last lane shows the last beat.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of systolic_skew_feeder_if (handshake + lane outputs)
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int DW   = DW_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_skew_feeder_if.slave bus
);

  localparam int DCW = $clog2(N);

  state_t          state_r, state_s;
  logic [DCW-1:0]  drain_cnt_r, drain_cnt_s;
  logic [CNTW-1:0] beat_cnt_r, beat_cnt_s;
  logic            in_ready_r, in_ready_s;
  logic            done_r, done_s;
  logic            accept_s;

  logic [DW-1:0]   lane_in_s   [N];
  logic [DW-1:0]   lane_data_s [N];
  logic [N-1:0]    lane_fire_s;
  logic [N*DW-1:0] a_out_s;

  // in_ready is a register, so acceptance never depends combinationally
  // on in_valid reaching back to in_ready.
  assign accept_s = bus.in_valid & in_ready_r;

  // State, counters and handshake/done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      drain_cnt_r <= {DCW{1'b0}};
      beat_cnt_r  <= {CNTW{1'b0}};
      in_ready_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      drain_cnt_r <= drain_cnt_s;
      beat_cnt_r  <= beat_cnt_s;
      in_ready_r  <= in_ready_s;
      done_r      <= done_s;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_s     = state_r;
    drain_cnt_s = drain_cnt_r;
    beat_cnt_s  = beat_cnt_r;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          beat_cnt_s = {{(CNTW-1){1'b0}}, 1'b1};
          if (bus.in_last) begin
            state_s     = DRAIN;
            drain_cnt_s = DCW'(N-1);
          end else begin
            state_s = STREAM;
          end
        end else begin
          state_s = IDLE;
        end
      end
      STREAM: begin
        if (accept_s) begin
          if (beat_cnt_r != {CNTW{1'b1}}) begin
            beat_cnt_s = beat_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
          end else begin
            beat_cnt_s = beat_cnt_r;
          end
          if (bus.in_last) begin
            state_s     = DRAIN;
            drain_cnt_s = DCW'(N-1);
          end else begin
            state_s = STREAM;
          end
        end else begin
          state_s = STREAM;
        end
      end
      DRAIN: begin
        // DRAIN spans N cycles (count N-1 down to 0). done is registered,
        // so decode it one count early to land with the last lane's slot.
        if (drain_cnt_r == {DCW{1'b0}}) begin
          state_s = IDLE;
        end else begin
          drain_cnt_s = drain_cnt_r - {{(DCW-1){1'b0}}, 1'b1};
        end
        if (drain_cnt_r == {{(DCW-1){1'b0}}, 1'b1}) begin
          done_s = 1'b1;
        end else begin
          done_s = 1'b0;
        end
      end
      default: begin
        state_s     = IDLE;
        drain_cnt_s = {DCW{1'b0}};
      end
    endcase
    in_ready_s = (state_s != DRAIN);
  end

  // Per-lane slot entering the skew: operand on accept, zero bubble otherwise.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (accept_s) begin
        lane_in_s[i] = bus.in_vec[i*DW +: DW];
      end else begin
        lane_in_s[i] = {DW{1'b0}};
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(
      .DEPTH (i + 1),
      .DW    (DW)
    ) u_delay (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (accept_s),
      .in_data   (lane_in_s[i]),
      .out_valid (lane_fire_s[i]),
      .out_data  (lane_data_s[i])
    );
  end

  // Pack lane operands into the flat output bus.
  always_comb begin
    a_out_s = {(N*DW){1'b0}};
    for (int i = 0; i < N; i++) begin
      a_out_s[i*DW +: DW] = lane_data_s[i];
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.fire     = lane_fire_s;
  assign bus.a_out    = a_out_s;
  assign bus.done     = done_r;
  assign bus.beat_cnt = beat_cnt_r;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with N=4, DW=8, CNTW=16.
// Inputs are driven 1 time unit after each rising edge and outputs are
// compared in the same window, i.e. each check sees the registered
// outputs of the current cycle.
module tb_systolic_skew_feeder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  systolic_skew_feeder_if #(.N(4), .DW(8), .CNTW(16)) bus ();

  systolic_skew_feeder #(.N(4), .DW(8), .CNTW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        last;
    logic [31:0] vec;
    logic        rdy;
    logic [3:0]  fire;
    logic [31:0] a;
    logic        done;
    logic [15:0] beat;
  } row_t;

  row_t tbl [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic rdy, input logic [3:0] fire,
                          input logic [31:0] a, input logic done);
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(rdy));
    chk({tag, ".fire"},     64'(bus.fire),     64'(fire));
    chk({tag, ".a_out"},    64'(bus.a_out),    64'(a));
    chk({tag, ".done"},     64'(bus.done),     64'(done));
  endtask

  // Lane i of beat k carries k*10+i.
  function automatic logic [31:0] mkvec(input int k);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'(k*10 + i);
    return r;
  endfunction

  initial begin
    logic [3:0]  ef;
    logic [31:0] ea;
    logic        seen;
    int          cnt;

    checks = 0;
    errors = 0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_vec   = 32'h0;

    // Single-beat skew (rows 0-5), then bubbles 1,0,1,1(last) (rows 6-14).
    tbl[0]  = '{1'b1, 1'b1, 32'h04030201, 1'b1, 4'b0000, 32'h00000000, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 4'b0001, 32'h00000001, 1'b0, 16'd1};
    tbl[2]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 4'b0010, 32'h00000200, 1'b0, 16'd1};
    tbl[3]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 4'b0100, 32'h00030000, 1'b0, 16'd1};
    tbl[4]  = '{1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 4'b1000, 32'h04000000, 1'b1, 16'd1};
    tbl[5]  = '{1'b0, 1'b1, 32'h00000000, 1'b1, 4'b0000, 32'h00000000, 1'b0, 16'd1};
    tbl[6]  = '{1'b1, 1'b0, 32'h13121110, 1'b1, 4'b0000, 32'h00000000, 1'b0, 16'd1};
    tbl[7]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 4'b0001, 32'h00000010, 1'b0, 16'd1};
    tbl[8]  = '{1'b1, 1'b0, 32'h23222120, 1'b1, 4'b0010, 32'h00001100, 1'b0, 16'd1};
    tbl[9]  = '{1'b1, 1'b1, 32'h33323130, 1'b1, 4'b0101, 32'h00120020, 1'b0, 16'd2};
    tbl[10] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 4'b1011, 32'h13002130, 1'b0, 16'd3};
    tbl[11] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 4'b0110, 32'h00223100, 1'b0, 16'd3};
    tbl[12] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 4'b1100, 32'h23320000, 1'b0, 16'd3};
    tbl[13] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 4'b1000, 32'h33000000, 1'b1, 16'd3};
    tbl[14] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 4'b0000, 32'h00000000, 1'b0, 16'd3};

    // Power-on reset.
    rst = 1'b1;
    tick();
    tick();
    chk("por.in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    tick();
    chk("por.in_ready_rel", 64'(bus.in_ready), 64'd1);
    chk("por.beat_cnt", 64'(bus.beat_cnt), 64'd0);

    // Reset mid-stream discards in-flight beats.
    bus.in_valid = 1'b1;
    bus.in_vec   = 32'hAABBCCDD;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_outs("rst_mid", 1'b0, 4'b0000, 32'h0, 1'b0);
    tick();
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk_outs("rst_rel", 1'b1, 4'b0000, 32'h0, 1'b0);
    chk("rst_rel.beat_cnt", 64'(bus.beat_cnt), 64'd0);
    tick();
    chk("rst_rel2.fire", 64'(bus.fire), 64'd0);

    // Table-driven skew and bubble vectors.
    for (int r = 0; r < 15; r++) begin
      bus.in_valid = tbl[r].v;
      bus.in_last  = tbl[r].last;
      bus.in_vec   = tbl[r].vec;
      chk_outs($sformatf("tbl%0d", r), tbl[r].rdy, tbl[r].fire, tbl[r].a, tbl[r].done);
      chk($sformatf("tbl%0d.beat_cnt", r), 64'(bus.beat_cnt), 64'(tbl[r].beat));
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;

    // Continuous stream: 8 beats, last on beat 8.
    for (int t = 0; t < 13; t++) begin
      bus.in_valid = (t < 8);
      bus.in_last  = (t == 7);
      bus.in_vec   = mkvec(t + 1);
      ef = 4'b0;
      ea = 32'h0;
      for (int i = 0; i < 4; i++) begin
        if (t - 1 - i >= 0 && t - 1 - i < 8) begin
          ef[i] = 1'b1;
          ea[i*8 +: 8] = 8'((t - i) * 10 + i);
        end
      end
      chk_outs($sformatf("cont%0d", t), !(t >= 8 && t <= 11), ef, ea, (t == 11));
      tick();
    end
    chk("cont.beat_cnt", 64'(bus.beat_cnt), 64'd8);

    // Backpressure: next vector held valid through DRAIN, accepted at L+N+1.
    for (int t = 0; t < 11; t++) begin
      bus.in_valid = (t <= 5);
      bus.in_last  = (t <= 5);
      bus.in_vec   = (t == 0) ? mkvec(5) : mkvec(9);
      ef = 4'b0;
      ea = 32'h0;
      for (int i = 0; i < 4; i++) begin
        if (t - 1 - i == 0) begin
          ef[i] = 1'b1;
          ea[i*8 +: 8] = 8'(50 + i);
        end else if (t - 1 - i == 5) begin
          ef[i] = 1'b1;
          ea[i*8 +: 8] = 8'(90 + i);
        end
      end
      chk_outs($sformatf("bp%0d", t), !((t >= 1 && t <= 4) || (t >= 6 && t <= 9)), ef, ea,
               (t == 4 || t == 9));
      if (t == 6) chk("bp.beat_cnt", 64'(bus.beat_cnt), 64'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;

    // Saturation: 65537 beats leave beat_cnt at 65535.
    bus.in_valid = 1'b1;
    bus.in_vec   = 32'h01010101;
    for (int n = 0; n < 65535; n++) tick();
    chk("sat.at_max", 64'(bus.beat_cnt), 64'd65535);
    tick();
    tick();
    chk("sat.hold", 64'(bus.beat_cnt), 64'd65535);
    bus.in_last = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("sat.last", 64'(bus.beat_cnt), 64'd65535);
    seen = 1'b0;
    cnt  = 0;
    while (!seen && cnt < 10) begin
      if (bus.done) seen = 1'b1;
      else begin
        tick();
        cnt++;
      end
    end
    chk("sat.done_seen", 64'(seen), 64'd1);
    chk("sat.done_lat", 64'(cnt), 64'd3);
    tick();
    chk("sat.ready_back", 64'(bus.in_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
